// File: rtl/pcs_tx_sched.sv
// Two-requester MII transmit scheduler. It generates tx_ce, inserts preamble and SFD, arbitrates
// whole frames round-robin, enforces the inter-packet gap and flags underruns.
// Optional feature: define DEFER_EN to hold off new grants while crs is asserted.
module pcs_tx_sched #(
    parameter int CE_DIV      = 5,
    parameter int PRE_NIBBLES = 15,
    parameter int IPG_NIBBLES = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    input  logic       crs,
    output logic       tx_ce,
    output logic       tx_en,
    output logic [3:0] txd,
    output logic       tx_er,
    output logic [1:0] grant,
    output logic       busy,
    output logic       underrun
);
    localparam int CE_W  = $clog2(CE_DIV) + 1;
    localparam int N_MAX = (PRE_NIBBLES > IPG_NIBBLES) ? PRE_NIBBLES : IPG_NIBBLES;
    localparam int N_W   = $clog2(N_MAX) + 1;
    localparam logic [CE_W-1:0] CE_LAST  = CE_W'(CE_DIV - 1);
    localparam logic [N_W-1:0]  PRE_LAST = N_W'(PRE_NIBBLES);
    // The IDLE nibble is the final gap nibble, so IPG itself lasts one nibble less.
    localparam logic [N_W-1:0]  IPG_LAST = N_W'(IPG_NIBBLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_LAST, S_IPG} state_t;

    state_t          state_q, state_d;
    logic [CE_W-1:0] ce_q;
    logic [N_W-1:0]  cnt_q, cnt_d;
    logic            tx_en_d, tx_er_d, rr_q, rr_d;
    logic [3:0]      txd_d, sel_data;
    logic [1:0]      grant_d;
    logic            owner, pick, in_xfer, defer, sel_valid, sel_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ce_q <= '0;
        else if (tx_ce) ce_q <= '0;
        else            ce_q <= ce_q + CE_W'(1);
    end

    assign tx_ce = (ce_q == CE_LAST);

`ifdef DEFER_EN
    assign defer = crs;
`else
    logic unused_crs;
    assign unused_crs = crs;
    assign defer      = 1'b0;
`endif

    assign owner     = grant[1];
    assign sel_valid = req_valid[owner];
    assign sel_last  = req_last[owner];
    assign sel_data  = owner ? req_data[7:4] : req_data[3:0];
    assign in_xfer   = (state_q == S_SFD) || (state_q == S_DATA);
    assign req_ready = (tx_ce && in_xfer) ? grant : 2'b00;
    assign underrun  = tx_ce && in_xfer && !sel_valid;
    assign busy      = (state_q != S_IDLE);
    // rr_q holds the last owner; on a tie the other requester wins.
    assign pick      = (&req_valid) ? ~rr_q : req_valid[1];

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_en_d = tx_en;
        txd_d   = txd;
        tx_er_d = tx_er;
        grant_d = grant;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if ((|req_valid) && !defer) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    tx_en_d = 1'b1;
                    txd_d   = 4'h5;
                    tx_er_d = 1'b0;
                    cnt_d   = N_W'(1);
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt_q < PRE_LAST) begin
                    cnt_d = cnt_q + N_W'(1);
                end else begin
                    txd_d   = 4'hD;
                    state_d = S_SFD;
                end
            end
            S_SFD, S_DATA: begin
                state_d = S_DATA;
                if (sel_valid) begin
                    txd_d   = sel_data;
                    tx_er_d = 1'b0;
                    if (sel_last) state_d = S_LAST;
                end else begin
                    txd_d   = 4'h0;
                    tx_er_d = 1'b1;
                end
            end
            S_LAST: begin
                tx_en_d = 1'b0;
                txd_d   = 4'h0;
                tx_er_d = 1'b0;
                cnt_d   = N_W'(1);
                state_d = S_IPG;
            end
            S_IPG: begin
                if (cnt_q < IPG_LAST) begin
                    cnt_d = cnt_q + N_W'(1);
                end else begin
                    rr_d    = grant[1];
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tx_en   <= 1'b0;
            txd     <= 4'h0;
            tx_er   <= 1'b0;
            grant   <= 2'b00;
            rr_q    <= 1'b1;
        end else if (tx_ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_en   <= tx_en_d;
            txd     <= txd_d;
            tx_er   <= tx_er_d;
            grant   <= grant_d;
            rr_q    <= rr_d;
        end
    end
endmodule
